uart_rx_8n1: RTL and testbench

- Serial receiver for 8N1 frames; the receive-side counterpart of the team's 8N1 transmitter.
- Sits directly downstream of the transmit pin or an external RX pad and recovers bytes.
- Synchronises the asynchronous line, validates the start bit, samples mid-bit, checks the stop bit, and presents each byte with a one-cycle valid strobe.

---
 rtl/uart_rx_8n1.sv | 145 ++++++++++++++
 tb/tb_uart_rx_8n1.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: synchronises rx, qualifies the start bit at mid-bit,
// samples each data bit at the centre of its period, checks the stop bit and
// presents the byte with a single-cycle valid strobe.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on rx_s
// START     | counting to the middle of the start bit to confirm it
// DATA      | sampling 8 data bits, LSB first, one per bit period
// STOP      | sampling the stop bit; good -> rxvalid, bad -> frame_err
// WAIT_IDLE | after a framing error, hold off until the line returns high
//
// CLKS_PER_BIT must be even and at least 4; SYNC_STAGES at least 2.

module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rxvalid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CW-1:0]          cyc_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous line into the clk domain; resets to idle-high so
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  // Frame state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rxbyte    <= 8'h00;
      rxvalid   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rxvalid   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cyc_cnt == HALF_M1) begin
            cyc_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        DATA: begin
          if (cyc_cnt == FULL_M1) begin
            cyc_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        STOP: begin
          // Leaving at mid stop bit leaves half a bit of margin to catch a
          // start bit that follows the stop bit directly.
          if (cyc_cnt == FULL_M1) begin
            cyc_cnt <= '0;
            if (rx_s) begin
              rxbyte  <= shift;
              rxvalid <= 1'b1;
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          cyc_cnt <= '0;
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cyc_cnt <= '0;
          bit_cnt <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: drives serial frames in real time (so sender bit
// periods need not be whole clock cycles) and compares received bytes,
// strobes and timing against a frame-level model.
`timescale 1ns/1ps

module tb_uart_rx_8n1;

  localparam real BIT_NS = 160.0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rxbyte;
  logic       rxvalid;
  logic       frame_err;
  logic       rx_busy;

  int checks = 0;
  int failures = 0;

  uart_rx_8n1 #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rxbyte(rxbyte), .rxvalid(rxvalid), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation of the outputs, sampled mid-cycle.
  logic [7:0]  got_q[$];
  int unsigned got_t[$];
  int          ferr_cnt = 0;
  bit          both_seen = 0;
  bit          hold_viol = 0;
  logic [7:0]  prev_byte = 8'h00;

  always @(negedge clk) begin
    if (rxvalid) begin
      got_q.push_back(rxbyte);
      got_t.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    if (rxvalid && frame_err) both_seen = 1;
    if (rst_n && !rxvalid && rxbyte !== prev_byte) hold_viol = 1;
    prev_byte = rxbyte;
  end

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input real bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop_ok;
    #(bit_ns);
  endtask

  task automatic align(output int unsigned t0);
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_t.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 rx = $urandom_range(0, 1);
    end
    @(negedge clk);
    checks++; if (rxbyte !== 8'h00) begin failures++; $display("FAIL reset_rxbyte got=%h exp=00", rxbyte); end
    checks++; if (rxvalid !== 1'b0) begin failures++; $display("FAIL reset_rxvalid got=%b exp=0", rxvalid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); end
    rx = 1'b1;
    #3 rst_n = 1'b1;
    clear_obs();
    repeat (40) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", rx_busy); end
    checks++; if (got_q.size() != 0 || ferr_cnt != 0) begin failures++; $display("FAIL reset_idle_outputs valids=%0d ferrs=%0d exp=0/0", got_q.size(), ferr_cnt); end
  endtask

  task automatic test_single();
    int unsigned t0;
    int lat;
    clear_obs();
    align(t0);
    send_frame(8'hA5, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL single_count got=%0d exp=1", got_q.size());
    end else begin
      lat = int'(got_t[0]) - int'(t0);
      checks++; if (got_q[0] !== 8'hA5) begin failures++; $display("FAIL single_byte got=%h exp=a5", got_q[0]); end
      checks++; if (lat < 153 || lat > 155) begin failures++; $display("FAIL single_latency got=%0d exp=154+-1", lat); end
    end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    int unsigned t0;
    logic [7:0] exp[3];
    int gap;
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
    clear_obs();
    align(t0);
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() != 3) begin
      failures++; $display("FAIL b2b_count got=%0d exp=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_q[i] !== exp[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        gap = int'(got_t[i]) - int'(got_t[i-1]);
        checks++; if (gap < 159 || gap > 161) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=160", i, gap); end
      end
    end
  endtask

  task automatic test_glitch();
    int unsigned t0;
    bit saw_busy = 0;
    int ferr0;
    clear_obs();
    ferr0 = ferr_cnt;
    align(t0);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (9) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1;
    end
    checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL glitch_seen got=%b exp=1", saw_busy); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_back_idle got=%b exp=0", rx_busy); end
    repeat (30) @(negedge clk);
    checks++; if (got_q.size() != 0 || ferr_cnt != ferr0) begin failures++; $display("FAIL glitch_no_output valids=%0d ferrs=%0d exp=0/0", got_q.size(), ferr_cnt - ferr0); end
    align(t0);
    send_frame(8'h5A, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    checks++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin failures++; $display("FAIL glitch_followup count=%0d byte=%h exp=1/5a", got_q.size(), rxbyte); end
  endtask

  task automatic test_frame_err();
    int unsigned t0;
    int ferr0;
    bit busy_all = 1;
    logic [7:0] prior;
    prior = rxbyte;
    clear_obs();
    ferr0 = ferr_cnt;
    align(t0);
    send_frame(8'h3C, 1'b0, BIT_NS);
    repeat (40) begin
      @(negedge clk);
      if (rx_busy !== 1'b1) busy_all = 0;
    end
    rx = 1'b1;
    repeat (32) @(negedge clk);
    checks++; if (ferr_cnt - ferr0 != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - ferr0); end
    checks++; if (rxbyte !== prior) begin failures++; $display("FAIL ferr_rxbyte_held got=%h exp=%h", rxbyte, prior); end
    checks++; if (busy_all !== 1'b1) begin failures++; $display("FAIL ferr_busy_low_line got=%b exp=1", busy_all); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ferr_no_retrigger got=%0d exp=0", got_q.size()); end
    align(t0);
    send_frame(8'h81, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    checks++; if (got_q.size() != 1 || rxbyte !== 8'h81) begin failures++; $display("FAIL ferr_followup count=%0d byte=%h exp=1/81", got_q.size(), rxbyte); end
  endtask

  task automatic test_reset_mid();
    int unsigned t0;
    int ferr0;
    logic [7:0] d;
    d = 8'hC3;
    clear_obs();
    ferr0 = ferr_cnt;
    align(t0);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      #(BIT_NS);
    end
    rx = d[4];
    #(BIT_NS / 2);
    rst_n = 1'b0;
    #30 rx = 1'b1;
    #20 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (got_q.size() != 0 || ferr_cnt != ferr0) begin failures++; $display("FAIL rstmid_no_output valids=%0d ferrs=%0d exp=0/0", got_q.size(), ferr_cnt - ferr0); end
    checks++; if (rxbyte !== 8'h00) begin failures++; $display("FAIL rstmid_rxbyte got=%h exp=00", rxbyte); end
    align(t0);
    send_frame(8'h96, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    checks++; if (got_q.size() != 1 || rxbyte !== 8'h96) begin failures++; $display("FAIL rstmid_followup count=%0d byte=%h exp=1/96", got_q.size(), rxbyte); end
  endtask

  // Random bytes, random sender rate within +-3%, occasional bad stop bits.
  task automatic test_random();
    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int ferr0;
    logic [7:0] d;
    bit good;
    real bns;
    clear_obs();
    ferr0 = ferr_cnt;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      bns = real'($urandom_range(1552, 1648)) / 10.0;
      #($urandom_range(0, 9));
      send_frame(d, good, bns);
      if (good) begin
        exp_q.push_back(d);
      end else begin
        exp_ferr++;
        #($urandom_range(0, 300));
        rx = 1'b1;
        #(bns);
      end
      #(bns);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (ferr_cnt - ferr0 != exp_ferr) begin failures++; $display("FAIL rand_ferr got=%0d exp=%0d", ferr_cnt - ferr0, exp_ferr); end
  endtask

  task automatic test_invariants();
    checks++; if (both_seen !== 1'b0) begin failures++; $display("FAIL valid_and_ferr_together got=%b exp=0", both_seen); end
    checks++; if (hold_viol !== 1'b0) begin failures++; $display("FAIL rxbyte_changed_without_valid got=%b exp=0", hold_viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
